// File: rtl/stage_mem_if.sv
// Data-SRAM-like bus between the memory stage and the data memory.
// Request: req/wr/size/addr/wstrb/wdata held stable until addr_ok; response: data_ok + rdata.
// The memory stage is the master; the memory (or bench model) is the slave.
interface stage_mem_if;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

// File: rtl/stage_mem.sv
// Memory-access stage: issues loads/stores on the data bus, aligns data, raises AdEL/AdES/RI.
// Latency: non-memory ops pass through combinationally; accesses take >=2 cycles (addr_ok, data_ok).
// Backpressure: stall_out held for the whole bus transaction; DONE holds its result while stall_in.
// Optional: STAGE_MEM_UNALIGNED_EN enables LWL/LWR/SWL/SWR (otherwise they raise RI).
module stage_mem #(
   parameter logic [4:0] EXC_ADEL = 5'h04,
   parameter logic [4:0] EXC_ADES = 5'h05
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        valid_in,
   output logic        valid_out,
   input  logic        stall_in,
   output logic        stall_out,
   input  logic        cancel,
   input  logic        exc_in,
   input  logic [4:0]  exccode_in,
   output logic        exc_out,
   output logic [4:0]  exccode_out,
   output logic [31:0] badvaddr_out,
   input  logic [3:0]  mem_op,
   input  logic [31:0] addr_in,
   input  logic [31:0] st_data_in,
   input  logic        wb_in,
   input  logic [4:0]  wb_addr_in,
   input  logic [31:0] wb_data_in,
   output logic        wb_out,
   output logic [4:0]  wb_addr_out,
   output logic [31:0] wb_data_out,
   stage_mem_if.master bus
);

   localparam logic [4:0] EXC_RI = 5'h0a;

   localparam logic [3:0] OP_NONE = 4'd0;
   localparam logic [3:0] OP_LB   = 4'd1;
   localparam logic [3:0] OP_LBU  = 4'd2;
   localparam logic [3:0] OP_LH   = 4'd3;
   localparam logic [3:0] OP_LHU  = 4'd4;
   localparam logic [3:0] OP_LW   = 4'd5;
   localparam logic [3:0] OP_SB   = 4'd6;
   localparam logic [3:0] OP_SH   = 4'd7;
   localparam logic [3:0] OP_SW   = 4'd8;
   localparam logic [3:0] OP_LWL  = 4'd9;
   localparam logic [3:0] OP_LWR  = 4'd10;
   localparam logic [3:0] OP_SWL  = 4'd11;
   localparam logic [3:0] OP_SWR  = 4'd12;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t      state, state_nxt;

   // captured instruction (held from acceptance until the bundle leaves DONE)
   logic [3:0]  op_q;
   logic [31:0] addr_q;
   logic [31:0] st_q;
   logic        wb_q;
   logic [4:0]  wb_addr_q;
   logic [31:0] rdata_q;

   logic        capture, rdata_ld, req_on;
   logic        in_load, in_store, in_addr_err, in_ri, in_exc, access;

   logic [3:0]  sel_op;
   logic [31:0] sel_addr, sel_st;
   logic [4:0]  sel_sh;

   logic        req_wr;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [3:0]  req_wstrb;
   logic [31:0] req_wdata;

   logic [31:0] lane;
   logic [31:0] ld_result;

   // Classify the incoming EX bundle: load/store, alignment fault, reserved op.
   always_comb begin
      in_load     = (mem_op >= OP_LB && mem_op <= OP_LW) || mem_op == OP_LWL || mem_op == OP_LWR;
      in_store    = (mem_op >= OP_SB && mem_op <= OP_SW) || mem_op == OP_SWL || mem_op == OP_SWR;
      in_addr_err = 1'b0;
      case (mem_op)
         OP_LH, OP_LHU, OP_SH: in_addr_err = addr_in[0];
         OP_LW, OP_SW:         in_addr_err = (addr_in[1:0] != 2'b00);
         default:              in_addr_err = 1'b0;
      endcase
`ifdef STAGE_MEM_UNALIGNED_EN
      in_ri  = (mem_op > OP_SWR);
`else
      in_ri  = (mem_op > OP_SW);
`endif
      in_exc = exc_in || in_ri || in_addr_err;
      access = valid_in && !exc_in && !cancel && (mem_op != OP_NONE) && !in_ri && !in_addr_err;
   end

   // Idle uses the live EX bundle; every later state uses the captured copy so the bus stays stable.
   always_comb begin
      if (state == S_IDLE) begin
         sel_op   = mem_op;
         sel_addr = addr_in;
         sel_st   = st_data_in;
      end else begin
         sel_op   = op_q;
         sel_addr = addr_q;
         sel_st   = st_q;
      end
      sel_sh = {sel_addr[1:0], 3'b000};
   end

   // Build bus request fields: size, byte strobes and lane-replicated store data.
   always_comb begin
      req_wr    = 1'b0;
      req_size  = 2'd0;
      req_addr  = sel_addr;
      req_wstrb = 4'b0000;
      req_wdata = 32'h0;
      case (sel_op)
         OP_LB, OP_LBU: req_size = 2'd0;
         OP_LH, OP_LHU: req_size = 2'd1;
         OP_LW:         req_size = 2'd2;
         OP_SB: begin
            req_wr    = 1'b1;
            req_size  = 2'd0;
            req_wstrb = 4'b0001 << sel_addr[1:0];
            req_wdata = {4{sel_st[7:0]}};
         end
         OP_SH: begin
            req_wr    = 1'b1;
            req_size  = 2'd1;
            req_wstrb = 4'b0011 << sel_addr[1:0];
            req_wdata = {2{sel_st[15:0]}};
         end
         OP_SW: begin
            req_wr    = 1'b1;
            req_size  = 2'd2;
            req_wstrb = 4'b1111;
            req_wdata = sel_st;
         end
`ifdef STAGE_MEM_UNALIGNED_EN
         OP_LWL, OP_LWR: begin
            req_size = 2'd2;
            req_addr = {sel_addr[31:2], 2'b00};
         end
         OP_SWL: begin
            req_wr    = 1'b1;
            req_size  = 2'd2;
            req_addr  = {sel_addr[31:2], 2'b00};
            req_wstrb = 4'b1111 >> (2'd3 - sel_addr[1:0]);
            req_wdata = sel_st >> {2'd3 - sel_addr[1:0], 3'b000};
         end
         OP_SWR: begin
            req_wr    = 1'b1;
            req_size  = 2'd2;
            req_addr  = {sel_addr[31:2], 2'b00};
            req_wstrb = 4'b1111 << sel_addr[1:0];
            req_wdata = sel_st << sel_sh;
         end
`endif
         default: ;
      endcase
   end

   // Align and extend the captured load word; LWL/LWR merge with the old rt value.
   always_comb begin
      lane      = rdata_q >> sel_sh;
      ld_result = rdata_q;
      case (sel_op)
         OP_LB:  ld_result = {{24{lane[7]}}, lane[7:0]};
         OP_LBU: ld_result = {24'h0, lane[7:0]};
         OP_LH:  ld_result = {{16{lane[15]}}, lane[15:0]};
         OP_LHU: ld_result = {16'h0, lane[15:0]};
`ifdef STAGE_MEM_UNALIGNED_EN
         OP_LWL: begin
            case (sel_addr[1:0])
               2'd0:    ld_result = {rdata_q[7:0],  sel_st[23:0]};
               2'd1:    ld_result = {rdata_q[15:0], sel_st[15:0]};
               2'd2:    ld_result = {rdata_q[23:0], sel_st[7:0]};
               default: ld_result = rdata_q;
            endcase
         end
         OP_LWR: begin
            case (sel_addr[1:0])
               2'd0:    ld_result = rdata_q;
               2'd1:    ld_result = {sel_st[31:24], rdata_q[31:8]};
               2'd2:    ld_result = {sel_st[31:16], rdata_q[31:16]};
               default: ld_result = {sel_st[31:8],  rdata_q[31:24]};
            endcase
         end
`endif
         default: ld_result = rdata_q;
      endcase
   end

   // FSM state register; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // Capture the accepted bundle and the returned load word.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         op_q      <= OP_NONE;
         addr_q    <= 32'h0;
         st_q      <= 32'h0;
         wb_q      <= 1'b0;
         wb_addr_q <= 5'd0;
         rdata_q   <= 32'h0;
      end else begin
         if (capture) begin
            op_q      <= mem_op;
            addr_q    <= addr_in;
            st_q      <= st_data_in;
            wb_q      <= wb_in && in_load;
            wb_addr_q <= wb_addr_in;
         end
         if (rdata_ld) rdata_q <= bus.data_rdata;
      end
   end

   // Next state, handshake and stage outputs.
   always_comb begin
      state_nxt    = state;
      capture      = 1'b0;
      rdata_ld     = 1'b0;
      req_on       = 1'b0;
      valid_out    = 1'b0;
      stall_out    = 1'b0;
      exc_out      = 1'b0;
      exccode_out  = 5'd0;
      badvaddr_out = 32'h0;
      wb_out       = 1'b0;
      wb_addr_out  = 5'd0;
      wb_data_out  = 32'h0;
      case (state)
         S_IDLE: begin
            if (access) begin
               req_on    = 1'b1;
               stall_out = 1'b1;
               capture   = 1'b1;
               if (bus.data_addr_ok) begin
                  if (bus.data_data_ok) begin
                     rdata_ld  = 1'b1;
                     state_nxt = S_DONE;
                  end else begin
                     state_nxt = S_WAIT;
                  end
               end else begin
                  state_nxt = S_REQ;
               end
            end else if (valid_in) begin
               stall_out   = stall_in;
               valid_out   = !stall_in && !cancel;
               exc_out     = in_exc && !cancel;
               wb_out      = wb_in && !in_exc && !cancel;
               wb_addr_out = wb_addr_in;
               wb_data_out = wb_data_in;
               if (exc_in) begin
                  exccode_out = exccode_in;
               end else if (in_ri) begin
                  exccode_out = EXC_RI;
               end else if (in_addr_err) begin
                  exccode_out  = in_store ? EXC_ADES : EXC_ADEL;
                  badvaddr_out = addr_in;
               end
            end
         end
         S_REQ: begin
            // request stays up in the cancel cycle, so an addr_ok here still owes a response
            req_on    = 1'b1;
            stall_out = 1'b1;
            if (bus.data_addr_ok) begin
               if (bus.data_data_ok) begin
                  rdata_ld  = !cancel;
                  state_nxt = cancel ? S_IDLE : S_DONE;
               end else begin
                  state_nxt = cancel ? S_DRAIN : S_WAIT;
               end
            end else if (cancel) begin
               state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            stall_out = 1'b1;
            if (cancel) begin
               state_nxt = bus.data_data_ok ? S_IDLE : S_DRAIN;
            end else if (bus.data_data_ok) begin
               rdata_ld  = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            valid_out   = !stall_in && !cancel;
            stall_out   = valid_in && stall_in;
            wb_out      = wb_q && !cancel;
            wb_addr_out = wb_addr_q;
            wb_data_out = ld_result;
            if (cancel || !stall_in) state_nxt = S_IDLE;
         end
         S_DRAIN: begin
            // a new access cannot start until the abandoned response has been swallowed
            stall_out = valid_in;
            if (bus.data_data_ok) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      bus.data_req   = req_on;
      bus.data_wr    = req_on ? req_wr    : 1'b0;
      bus.data_size  = req_on ? req_size  : 2'd0;
      bus.data_addr  = req_on ? req_addr  : 32'h0;
      bus.data_wstrb = req_on ? req_wstrb : 4'b0000;
      bus.data_wdata = req_on ? req_wdata : 32'h0;
   end

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: loads, stores, address errors, cancels, reset mid-transaction.
// Bus responses are driven cycle by cycle; expected values are hand-computed constants.
// Build with STAGE_MEM_UNALIGNED_EN to exercise the LWL/SWL path instead of the RI path.
module tb_stage_mem;

   logic        clk;
   logic        resetn;
   logic        valid_in, stall_in, cancel, exc_in, wb_in;
   logic [4:0]  exccode_in, wb_addr_in;
   logic [3:0]  mem_op;
   logic [31:0] addr_in, st_data_in, wb_data_in;
   logic        valid_out, stall_out, exc_out, wb_out;
   logic [4:0]  exccode_out, wb_addr_out;
   logic [31:0] badvaddr_out, wb_data_out;

   int n_vec = 0;
   int n_miscmp = 0;

   stage_mem_if bus_if ();

   stage_mem dut (
      .clk          (clk),
      .resetn       (resetn),
      .valid_in     (valid_in),
      .valid_out    (valid_out),
      .stall_in     (stall_in),
      .stall_out    (stall_out),
      .cancel       (cancel),
      .exc_in       (exc_in),
      .exccode_in   (exccode_in),
      .exc_out      (exc_out),
      .exccode_out  (exccode_out),
      .badvaddr_out (badvaddr_out),
      .mem_op       (mem_op),
      .addr_in      (addr_in),
      .st_data_in   (st_data_in),
      .wb_in        (wb_in),
      .wb_addr_in   (wb_addr_in),
      .wb_data_in   (wb_data_in),
      .wb_out       (wb_out),
      .wb_addr_out  (wb_addr_out),
      .wb_data_out  (wb_data_out),
      .bus          (bus_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid_in   = 1'b0;
      stall_in   = 1'b0;
      cancel     = 1'b0;
      exc_in     = 1'b0;
      exccode_in = 5'd0;
      mem_op     = 4'd0;
      addr_in    = 32'h0;
      st_data_in = 32'h0;
      wb_in      = 1'b0;
      wb_addr_in = 5'd0;
      wb_data_in = 32'h0;
      bus_if.data_addr_ok = 1'b0;
      bus_if.data_data_ok = 1'b0;
      bus_if.data_rdata   = 32'h0;
   endtask

   task automatic drive_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] st,
                           input logic wb);
      valid_in   = 1'b1;
      mem_op     = op;
      addr_in    = addr;
      st_data_in = st;
      wb_in      = wb;
      wb_addr_in = 5'd7;
      wb_data_in = 32'h5555_5555;
   endtask

   // One full access: optional addr_ok delay, split or same-cycle responses, result checked in DONE.
   task automatic access(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] st, input logic [31:0] rdata, input int addr_delay,
                         input logic same_cycle, input logic [31:0] exp_baddr,
                         input logic [1:0] exp_size, input logic exp_wr, input logic [3:0] exp_wstrb,
                         input logic [31:0] exp_bwdata, input logic exp_wb,
                         input logic [31:0] exp_result);
      cyc();
      idle_inputs();
      drive_op(op, addr, st, exp_wb);
      for (int i = 0; i < addr_delay; i++) begin
         @(negedge clk);
         chk({tag, " req_wait"}, bus_if.data_req, 1);
         chk({tag, " addr_wait"}, bus_if.data_addr, exp_baddr);
         cyc();
      end
      bus_if.data_addr_ok = 1'b1;
      bus_if.data_data_ok = same_cycle;
      bus_if.data_rdata   = rdata;
      @(negedge clk);
      chk({tag, " req"}, bus_if.data_req, 1);
      chk({tag, " addr"}, bus_if.data_addr, exp_baddr);
      chk({tag, " size"}, bus_if.data_size, exp_size);
      chk({tag, " wr"}, bus_if.data_wr, exp_wr);
      chk({tag, " wstrb"}, bus_if.data_wstrb, exp_wstrb);
      chk({tag, " wdata"}, bus_if.data_wdata, exp_bwdata);
      chk({tag, " stall_req"}, stall_out, 1);
      if (!same_cycle) begin
         cyc();
         bus_if.data_addr_ok = 1'b0;
         bus_if.data_data_ok = 1'b1;
         bus_if.data_rdata   = rdata;
         @(negedge clk);
         chk({tag, " req_drop"}, bus_if.data_req, 0);
         chk({tag, " stall_wait"}, stall_out, 1);
         chk({tag, " valid_wait"}, valid_out, 0);
      end
      cyc();
      bus_if.data_addr_ok = 1'b0;
      bus_if.data_data_ok = 1'b0;
      bus_if.data_rdata   = 32'h0;
      @(negedge clk);
      chk({tag, " valid_done"}, valid_out, 1);
      chk({tag, " stall_done"}, stall_out, 0);
      chk({tag, " wb"}, wb_out, exp_wb);
      if (exp_wb) begin
         chk({tag, " wb_data"}, wb_data_out, exp_result);
         chk({tag, " wb_addr"}, wb_addr_out, 7);
      end
      cyc();
      idle_inputs();
   endtask

   task automatic exc_case(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [4:0] exp_code, input logic [31:0] exp_bad);
      cyc();
      idle_inputs();
      drive_op(op, addr, 32'h0, 1'b1);
      @(negedge clk);
      chk({tag, " exc"}, exc_out, 1);
      chk({tag, " code"}, exccode_out, exp_code);
      chk({tag, " badvaddr"}, badvaddr_out, exp_bad);
      chk({tag, " no_req"}, bus_if.data_req, 0);
      chk({tag, " wb"}, wb_out, 0);
      chk({tag, " stall"}, stall_out, 0);
      chk({tag, " valid"}, valid_out, 1);
      cyc();
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      resetn = 1'b0;
      #12;
      chk("rst req", bus_if.data_req, 0);
      chk("rst valid", valid_out, 0);
      chk("rst stall", stall_out, 0);
      chk("rst exc", exc_out, 0);
      chk("rst wb", wb_out, 0);
      chk("rst addr", bus_if.data_addr, 0);
      chk("rst wb_data", wb_data_out, 0);
      #10 resetn = 1'b1;

      // loads: split / same-cycle / delayed addr_ok
      access("lw", 4'd5, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 1'b0, 32'h1000, 2'd2, 1'b0, 4'h0,
             32'h0, 1'b1, 32'hDEADBEEF);
      access("lb", 4'd1, 32'h1003, 32'h0, 32'h80112233, 0, 1'b0, 32'h1003, 2'd0, 1'b0, 4'h0,
             32'h0, 1'b1, 32'hFFFFFF80);
      access("lbu", 4'd2, 32'h1003, 32'h0, 32'h80112233, 0, 1'b1, 32'h1003, 2'd0, 1'b0, 4'h0,
             32'h0, 1'b1, 32'h00000080);
      access("lh", 4'd3, 32'h1002, 32'h0, 32'h80112233, 1, 1'b0, 32'h1002, 2'd1, 1'b0, 4'h0,
             32'h0, 1'b1, 32'hFFFF8011);
      access("lhu", 4'd4, 32'h1000, 32'h0, 32'h80118233, 0, 1'b0, 32'h1000, 2'd1, 1'b0, 4'h0,
             32'h0, 1'b1, 32'h00008233);
      // stores
      access("sh", 4'd7, 32'h2002, 32'h0000ABCD, 32'h0, 0, 1'b0, 32'h2002, 2'd1, 1'b1, 4'b1100,
             32'hABCDABCD, 1'b0, 32'h0);
      access("sb", 4'd6, 32'h3001, 32'h000000A5, 32'h0, 1, 1'b1, 32'h3001, 2'd0, 1'b1, 4'b0010,
             32'hA5A5A5A5, 1'b0, 32'h0);
      access("sw", 4'd8, 32'h4000, 32'hCAFEF00D, 32'h0, 0, 1'b0, 32'h4000, 2'd2, 1'b1, 4'b1111,
             32'hCAFEF00D, 1'b0, 32'h0);

      // address errors and inherited exception
      exc_case("adel_lw", 4'd5, 32'h1002, 5'h04, 32'h1002);
      exc_case("adel_lh", 4'd3, 32'h1001, 5'h04, 32'h1001);
      exc_case("ades_sw", 4'd8, 32'h2001, 5'h05, 32'h2001);
      cyc();
      drive_op(4'd5, 32'h1000, 32'h0, 1'b1);
      exc_in = 1'b1;
      exccode_in = 5'h0c;
      @(negedge clk);
      chk("exc_in exc", exc_out, 1);
      chk("exc_in code", exccode_out, 5'h0c);
      chk("exc_in no_req", bus_if.data_req, 0);

      // pass-through with and without downstream stall
      cyc();
      idle_inputs();
      drive_op(4'd0, 32'h0, 32'h0, 1'b1);
      wb_data_in = 32'h12345678;
      @(negedge clk);
      chk("pass valid", valid_out, 1);
      chk("pass wb", wb_out, 1);
      chk("pass data", wb_data_out, 32'h12345678);
      chk("pass stall", stall_out, 0);
      cyc();
      stall_in = 1'b1;
      @(negedge clk);
      chk("pass_st valid", valid_out, 0);
      chk("pass_st stall", stall_out, 1);

      // cancel in WAIT: response is swallowed, no write-back
      cyc();
      idle_inputs();
      drive_op(4'd5, 32'h1000, 32'h0, 1'b1);
      bus_if.data_addr_ok = 1'b1;
      cyc();
      idle_inputs();
      cancel = 1'b1;
      @(negedge clk);
      chk("cw valid", valid_out, 0);
      cyc();
      cancel = 1'b0;
      bus_if.data_data_ok = 1'b1;
      bus_if.data_rdata   = 32'h99999999;
      @(negedge clk);
      chk("cw drain valid", valid_out, 0);
      chk("cw drain wb", wb_out, 0);
      access("after_cw", 4'd5, 32'h1004, 32'h0, 32'h01020304, 0, 1'b0, 32'h1004, 2'd2, 1'b0,
             4'h0, 32'h0, 1'b1, 32'h01020304);

      // cancel in REQ: request held during the cancel cycle, dropped after
      cyc();
      drive_op(4'd5, 32'h1000, 32'h0, 1'b1);
      cyc();
      idle_inputs();
      cancel = 1'b1;
      @(negedge clk);
      chk("cr req_hold", bus_if.data_req, 1);
      cyc();
      cancel = 1'b0;
      @(negedge clk);
      chk("cr req_drop", bus_if.data_req, 0);
      chk("cr valid", valid_out, 0);

      // DONE held under stall_in, then cancel in DONE
      cyc();
      drive_op(4'd5, 32'h1008, 32'h0, 1'b1);
      stall_in = 1'b1;
      bus_if.data_addr_ok = 1'b1;
      bus_if.data_data_ok = 1'b1;
      bus_if.data_rdata   = 32'h0BADF00D;
      cyc();
      bus_if.data_addr_ok = 1'b0;
      bus_if.data_data_ok = 1'b0;
      @(negedge clk);
      chk("ds valid", valid_out, 0);
      chk("ds stall", stall_out, 1);
      chk("ds data", wb_data_out, 32'h0BADF00D);
      cyc();
      cancel = 1'b1;
      @(negedge clk);
      chk("cd wb", wb_out, 0);
      chk("cd valid", valid_out, 0);
      cyc();
      idle_inputs();

      // reset in the middle of a transaction
      drive_op(4'd5, 32'h1000, 32'h0, 1'b1);
      bus_if.data_addr_ok = 1'b1;
      cyc();
      idle_inputs();
      #1 resetn = 1'b0;
      #1;
      chk("mrst req", bus_if.data_req, 0);
      chk("mrst stall", stall_out, 0);
      chk("mrst valid", valid_out, 0);
      #2 resetn = 1'b1;
      access("after_rst", 4'd5, 32'h100C, 32'h0, 32'h76543210, 0, 1'b0, 32'h100C, 2'd2, 1'b0,
             4'h0, 32'h0, 1'b1, 32'h76543210);

`ifdef STAGE_MEM_UNALIGNED_EN
      access("lwl", 4'd9, 32'h1001, 32'h11223344, 32'hAABBCCDD, 0, 1'b0, 32'h1000, 2'd2, 1'b0,
             4'h0, 32'h0, 1'b1, 32'hCCDD3344);
      access("swl", 4'd11, 32'h1001, 32'h11223344, 32'h0, 0, 1'b0, 32'h1000, 2'd2, 1'b1,
             4'b0011, 32'h00001122, 1'b0, 32'h0);
`else
      exc_case("ri_lwl", 4'd9, 32'h1001, 5'h0a, 32'h0);
      exc_case("ri_swr", 4'd12, 32'h1002, 5'h0a, 32'h0);
`endif

      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
